// File: rtl/cpa_prefix_pipe_if.sv
// Operand/result handshake bundle for cpa_prefix_pipe.
// The ovf signal exists only when CPA_PIPE_OVF_EN is defined.
interface cpa_prefix_pipe_if #(
   parameter int unsigned BIT_LEN = 17
);
   logic               in_valid;
   logic               in_ready;
   logic [BIT_LEN-1:0] a;
   logic [BIT_LEN-1:0] b;
   logic               cin;
   logic               out_valid;
   logic               out_ready;
   logic [BIT_LEN-1:0] sum;
   logic               cout;
`ifdef CPA_PIPE_OVF_EN
   logic               ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
`endif
endinterface

// File: rtl/cpa_prefix_pipe.sv
// Pipelined Kogge-Stone carry-propagate adder with valid/ready flow control.
// Define CPA_PIPE_OVF_EN to add the signed-overflow output ovf.
module cpa_prefix_pipe #(
   parameter int unsigned BIT_LEN   = 17,
   parameter int unsigned REG_EVERY = 2
) (
   input logic              clk,
   input logic              rst_n,
   cpa_prefix_pipe_if.slave bus
);
   localparam int unsigned LEVELS = $clog2(BIT_LEN);
   localparam int unsigned NSTAGE = 1 + (LEVELS + REG_EVERY - 1) / REG_EVERY;
   localparam int unsigned LAST   = NSTAGE - 1;

   // g/p hold the group generate/propagate so far; p0 is the original per-bit propagate.
   logic [BIT_LEN-1:0] g_q   [NSTAGE];
   logic [BIT_LEN-1:0] g_d   [NSTAGE];
   logic [BIT_LEN-1:0] p_q   [NSTAGE];
   logic [BIT_LEN-1:0] p_d   [NSTAGE];
   logic [BIT_LEN-1:0] p0_q  [NSTAGE];
   logic [BIT_LEN-1:0] p0_d  [NSTAGE];
   logic               cin_q [NSTAGE];
   logic               cin_d [NSTAGE];
   logic [NSTAGE-1:0]  valid_q;
   logic [NSTAGE-1:0]  valid_d;
   logic [NSTAGE-1:0]  ready;

   always_comb begin : ready_chain
      logic rdy;
      rdy = bus.out_ready;
      for (int s = int'(NSTAGE) - 1; s >= 0; s--) begin
         rdy      = !valid_q[s] || rdy;
         ready[s] = rdy;
      end
   end

   always_comb begin : valid_next
      valid_d[0] = ready[0] ? bus.in_valid : valid_q[0];
      for (int s = 1; s < int'(NSTAGE); s++) begin
         valid_d[s] = ready[s] ? valid_q[s-1] : valid_q[s];
      end
   end

   always_comb begin : datapath_next
      logic [BIT_LEN-1:0] cg;
      logic [BIT_LEN-1:0] cp;
      int                 k;
      int                 d;
      g_d   = '{default: '0};
      p_d   = '{default: '0};
      p0_d  = '{default: '0};
      cin_d = '{default: 1'b0};
      cg    = '0;
      cp    = '0;
      k     = 0;
      d     = 0;

      p_d[0]      = bus.a ^ bus.b;
      g_d[0]      = bus.a & bus.b;
      g_d[0][0]   = (bus.a[0] & bus.b[0]) | (p_d[0][0] & bus.cin);
      p0_d[0]     = p_d[0];
      cin_d[0]    = bus.cin;

      for (int s = 1; s < int'(NSTAGE); s++) begin
         cg = g_q[s-1];
         cp = p_q[s-1];
         for (int j = 1; j <= int'(REG_EVERY); j++) begin
            k = (s - 1) * int'(REG_EVERY) + j;
            if (k <= int'(LEVELS)) begin
               d = 1 << (k - 1);
               // Walk downward so bit i-d still holds the previous level's value.
               for (int i = int'(BIT_LEN) - 1; i >= 1; i--) begin
                  if (i >= d) begin
                     cg[i] = cg[i] | (cp[i] & cg[i-d]);
                     cp[i] = cp[i] & cp[i-d];
                  end
               end
            end
         end
         g_d[s]   = cg;
         p_d[s]   = cp;
         p0_d[s]  = p0_q[s-1];
         cin_d[s] = cin_q[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < int'(NSTAGE); s++) begin
         if (ready[s]) begin
            g_q[s]   <= g_d[s];
            p_q[s]   <= p_d[s];
            p0_q[s]  <= p0_d[s];
            cin_q[s] <= cin_d[s];
         end
      end
   end

   assign bus.in_ready  = ready[0];
   assign bus.out_valid = valid_q[LAST];
   assign bus.sum       = p0_q[LAST] ^ {g_q[LAST][BIT_LEN-2:0], cin_q[LAST]};
   assign bus.cout      = g_q[LAST][BIT_LEN-1];
`ifdef CPA_PIPE_OVF_EN
   assign bus.ovf       = g_q[LAST][BIT_LEN-2] ^ g_q[LAST][BIT_LEN-1];
`endif
endmodule
